// File: rtl/key_cond.sv
// key_cond: button synchroniser, debouncer and auto-repeater feeding the
// game control FSM with held move requests and a one-cycle start pulse.
module key_cond #(
  parameter int DEB_CYCLES   = 20,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_start_raw,
  input  logic key_right_raw,
  input  logic key_left_raw,
  input  logic key_down_raw,
  input  logic key_rotate_raw,
  input  logic hold_ack,
  input  logic flush,
  output logic start,
  output logic right,
  output logic left,
  output logic down,
  output logic rotate
);

  localparam int DW   = $clog2(DEB_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  // key index: 0 start, 1 right, 2 left, 3 down, 4 rotate
  logic [4:0] raw;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] press;
  logic [4:1] rep;

  assign raw = {key_rotate_raw, key_down_raw, key_left_raw,
                key_right_raw, key_start_raw};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar k = 0; k < 5; k++) begin : g_key
    logic [DW-1:0] cnt;
    logic          lvl;
    logic          fire;

    assign fire = (s2[k] != lvl) &&
                  (cnt == DW'(DEB_CYCLES - 1));
    assign press[k] = fire & s2[k];

    always_ff @(posedge clk) begin
      if (rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[k] == lvl) begin
        cnt <= '0;
      end else if (fire) begin
        lvl <= s2[k];
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    if (k >= 1 && k <= 3) begin : g_rep
      logic [RW-1:0] rcnt;
      logic [RW-1:0] thr;
      logic          rmode;
      logic          fall;

      // rmode=0 waits the initial delay, rmode=1 the repeat period
      assign fall   = fire & ~s2[k];
      assign thr    = rmode ? RW'(REPEAT_RATE - 1)
                            : RW'(REPEAT_DELAY - 1);
      assign rep[k] = lvl & ~fall & (rcnt == thr);

      always_ff @(posedge clk) begin
        if (rst_n) begin
          rcnt  <= '0;
          rmode <= 1'b0;
        end else if (press[k] || !lvl || fall) begin
          rcnt  <= '0;
          rmode <= 1'b0;
        end else if (rep[k]) begin
          rcnt  <= '0;
          rmode <= 1'b1;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end
    end else if (k == 4) begin : g_norep
      assign rep[k] = 1'b0;
    end
  end

  // move index: 0 right, 1 left, 2 down, 3 rotate
  logic [3:0] mv_ev;
  logic [3:0] pend_q;
  logic [3:0] pend_n;
  logic [3:0] out_q;
  logic [3:0] out_n;
  logic [3:0] cons;
  logic [3:0] sel;
  logic       start_q;

  assign mv_ev = press[4:1] | rep[4:1];
  assign cons  = out_q & {4{hold_ack}};

  // down > right > left > rotate
  always_comb begin
    sel = '0;
    unique case (1'b1)
      pend_q[2]:
        sel[2] = 1'b1;
      pend_q[0] & ~pend_q[2]:
        sel[0] = 1'b1;
      pend_q[1] & ~pend_q[2] & ~pend_q[0]:
        sel[1] = 1'b1;
      pend_q[3] & ~|pend_q[2:0]:
        sel[3] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pend_n = pend_q;
    out_n  = out_q;
    if (flush) begin
      pend_n = '0;
      out_n  = '0;
    end else begin
      pend_n = (pend_q | mv_ev) & ~cons;
      out_n  = out_q & ~cons;
      if (out_q == '0) begin
        out_n = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pend_q  <= '0;
      out_q   <= '0;
      start_q <= 1'b0;
    end else begin
      pend_q  <= pend_n;
      out_q   <= out_n;
      start_q <= press[0];
    end
  end

  assign start  = start_q;
  assign right  = out_q[0];
  assign left   = out_q[1];
  assign down   = out_q[2];
  assign rotate = out_q[3];

endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond: directed cycle-exact checks of key_cond with
// DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5.
module tb_key_cond;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_start_raw = 1'b0;
  logic key_right_raw = 1'b0;
  logic key_left_raw = 1'b0;
  logic key_down_raw = 1'b0;
  logic key_rotate_raw = 1'b0;
  logic hold_ack = 1'b0;
  logic flush = 1'b0;
  logic start, right, left, down, rotate;

  int n_pass = 0;
  int n_tot = 0;

  // observed vector {start, down, right, left, rotate}
  localparam logic [4:0] Z = 5'b00000;
  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] D = 5'b01000;
  localparam logic [4:0] R = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] O = 5'b00001;

  key_cond #(
    .DEB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_start_raw(key_start_raw),
    .key_right_raw(key_right_raw),
    .key_left_raw(key_left_raw),
    .key_down_raw(key_down_raw),
    .key_rotate_raw(key_rotate_raw),
    .hold_ack(hold_ack),
    .flush(flush),
    .start(start),
    .right(right),
    .left(left),
    .down(down),
    .rotate(rotate)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {start, down, right, left, rotate};
  endfunction

  task automatic chk(input string tag,
                     input logic [4:0] obs,
                     input logic [4:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s idle%0d", tag, i), outs(), Z);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset", outs(), Z);
    tick();
    rst_n = 1'b0;
    idle("post_reset", 8);

    // short glitches never debounce
    hold_ack = 1'b1;
    for (int p = 0; p < 5; p++) begin
      key_right_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk($sformatf("glitch p%0d h%0d", p, i), outs(), Z);
      end
      key_right_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk($sformatf("glitch p%0d l%0d", p, i), outs(), Z);
      end
    end
    idle("glitch", 10);

    // single press: one-cycle request at cycle 7
    key_right_raw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("press c%0d", c), outs(),
          (c == 7) ? R : Z);
      if (c == 8) key_right_raw = 1'b0;
    end
    idle("press", 10);

    // auto-repeat of down
    key_down_raw = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      chk($sformatf("repeat c%0d", c), outs(),
          (c inside {7, 17, 22, 27, 32, 37, 42}) ? D : Z);
      if (c == 38) key_down_raw = 1'b0;
    end

    // simultaneous presses, priority and hold
    hold_ack = 1'b0;
    key_rotate_raw = 1'b1;
    key_left_raw = 1'b1;
    key_down_raw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("prio c%0d", c), outs(),
          (c >= 7) ? D : Z);
      if (c == 8) begin
        key_rotate_raw = 1'b0;
        key_left_raw = 1'b0;
        key_down_raw = 1'b0;
      end
    end
    hold_ack = 1'b1;
    tick();
    chk("prio consume_down", outs(), Z);
    hold_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("prio left%0d", i), outs(), L);
    end
    hold_ack = 1'b1;
    tick();
    chk("prio consume_left", outs(), Z);
    hold_ack = 1'b0;
    tick();
    chk("prio rotate0", outs(), O);
    tick();
    chk("prio rotate1", outs(), O);
    hold_ack = 1'b1;
    tick();
    chk("prio consume_rotate", outs(), Z);
    hold_ack = 1'b0;
    idle("prio", 5);

    // start pulse ignores hold_ack and flush
    flush = 1'b1;
    key_start_raw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("start c%0d", c), outs(),
          (c == 6) ? S : Z);
    end
    key_start_raw = 1'b0;
    tick();
    chk("start bounce0", outs(), Z);
    tick();
    chk("start bounce1", outs(), Z);
    key_start_raw = 1'b1;
    idle("start_held", 15);
    key_start_raw = 1'b0;
    idle("start_rel", 15);
    key_start_raw = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("restart c%0d", c), outs(),
          (c == 6) ? S : Z);
    end
    key_start_raw = 1'b0;
    idle("restart", 15);
    flush = 1'b0;

    // flush drops a presented request
    key_right_raw = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("flush c%0d", c), outs(),
          (c >= 7) ? R : Z);
      if (c == 8) key_right_raw = 1'b0;
    end
    flush = 1'b1;
    tick();
    chk("flush clear", outs(), Z);
    flush = 1'b0;
    idle("flush", 15);

    // reset mid-repeat
    hold_ack = 1'b1;
    key_down_raw = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("rst_rep c%0d", c), outs(),
          (c == 7) ? D : Z);
    end
    rst_n = 1'b1;
    key_down_raw = 1'b0;
    tick();
    chk("rst_rep reset", outs(), Z);
    rst_n = 1'b0;
    idle("rst_rep", 40);
    key_down_raw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("rst_fresh c%0d", c), outs(),
          (c == 7) ? D : Z);
      if (c == 8) key_down_raw = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/key_cond.md
Name: key_cond

Overview:
- Input-conditioning stage directly upstream of the game control FSM.
- Takes five raw, asynchronous, active-high push-button levels (start, right, left, down, rotate).
- Synchronises and debounces each button, then generates press events; right/left/down also auto-repeat while held.
- Move events are presented to the FSM as held requests, released only when the FSM is in its hold state (hold_ack); start is a one-cycle pulse.

Parameters:
- DEB_CYCLES, 20: consecutive cycles a synchronised level must be stable before the debounced level follows it (≥2).
- REPEAT_DELAY, 250: cycles from press event to first auto-repeat event (≥2).
- REPEAT_RATE, 60: cycles between subsequent auto-repeat events (≥2).
- Counter widths: $clog2(max value)+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, asserted HIGH (legacy name kept; active-high, sampled on clk rising edge)
- key_start_raw  in  1  raw start button, async, 1=pressed
- key_right_raw  in  1  raw right button
- key_left_raw  in  1  raw left button
- key_down_raw  in  1  raw down button
- key_rotate_raw  in  1  raw rotate button
- hold_ack  in  1  FSM hold-state indicator; a request is consumed when its output=1 and hold_ack=1 in the same cycle
- flush  in  1  drop all pending/presented move requests (driven from gen_new)
- start  out  1  one-cycle pulse per debounced start press
- right  out  1  move-right request, held until consumed
- left  out  1  move-left request
- down  out  1  soft-drop request
- rotate  out  1  rotate request

Behaviour:
- Reset (rst_n=1 at a clk edge): all sync flops, debounced levels, counters, pend flags and outputs go to 0. Takes priority over every other event and aborts any debounce or repeat in progress.
- Sync: each raw input passes through 2 flops. Only the second flop feeds logic.
- Debounce, per key:
  - deb counter clears whenever sync == db_level.
  - Otherwise it increments; when it reaches DEB_CYCLES-1, db_level <= sync and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes db_level.
  - Latency from a stable raw change to the db_level change is 2+DEB_CYCLES cycles.
- Press event: db_level 0->1.
- Auto-repeat (right/left/down only):
  - rep counter clears on the press event and counts while db_level=1.
  - The first repeat event fires when the count reaches REPEAT_DELAY. Further events fire every REPEAT_RATE cycles after that.
  - db_level 1->0 clears the counter; no event on release.
  - rotate and start never repeat.
- Start: a press event drives start=1 for exactly the next cycle, independent of hold_ack and flush.
- Pending: each move key has a pend flag, set by its event.
  - An event for a key already pending, or currently presented, is dropped; there is no counting queue.
- Presentation:
  - At most one of right/left/down/rotate is 1 at a time.
  - When none is presented, the highest-priority pending key is loaded into its output register on the next edge. Priority: down > right > left > rotate.
  - A presented output stays 1 until a cycle with output=1 and hold_ack=1. On that edge the output and its pend flag clear.
  - The next pending key may be presented one cycle later, never back-to-back in the same cycle.
  - Minimum request width is 1 cycle; an output is never 1 for less than one full cycle.
- Flush: on an edge with flush=1, all pend flags and move outputs clear. Move events generated in that same cycle are dropped. Start is unaffected.
- Simultaneous cases:
  - A consume and a new event for the same key in one cycle: the consume wins and the event is dropped.
  - Events for different keys in one cycle all set their pend flags.
- Outputs are registered only; there is no combinational path from raw inputs or hold_ack to outputs.

Test Plan:
- DEB_CYCLES=4: raw right pulses of 3 cycles, repeated 5 times -> right stays 0; db_level never changes.
- DEB_CYCLES=4, hold_ack=1 permanently: raw right 0->1 at cycle 0, held 8 cycles -> right=1 in exactly one cycle, at cycle 7 (2 sync + 4 debounce + 1 present), then 0.
- REPEAT_DELAY=10, REPEAT_RATE=5, hold_ack=1: down held 40 cycles after debounce -> down pulses at press+1, +11, +16, +21, +26, +31, +36 (7 pulses); no pulse after release.
- hold_ack=0: press rotate, then left, then down (all debounced) -> only down=1, held indefinitely. Raise hold_ack 1 cycle -> down clears; next cycle right stays 0 and left=1; after the next ack, rotate=1.
- Start press with hold_ack=0 and flush=1 -> start=1 for exactly 1 cycle; a second press while held gives no extra pulse until release and re-press.
- Right pending and presented, flush=1 for 1 cycle -> right=0 next cycle, pend cleared. Assert rst_n mid-repeat of down -> all outputs 0 next cycle; no repeat after rst_n deasserts until a fresh debounced press.
